sram_dp_fwd: RTL and testbench



---
 rtl/sram_pkg.sv | 33 +++
 rtl/sram_rd_pipe.sv | 55 +++++
 rtl/sram_dp_fwd.sv | 118 +++++++++++
 tb/tb_sram_dp_fwd.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared helpers for the dual-port SRAM model: lane-mask sizing, masked lane merge
// and the decoded per-port request kind.
package sram_pkg;

  localparam int unsigned MAX_DATA_W = 1024;
  localparam int unsigned MAX_LANES  = 1024;

  typedef enum logic [1:0] {
    REQ_IDLE,
    REQ_READ,
    REQ_WRITE
  } req_e;

  function automatic int unsigned num_wmasks(input int unsigned dw, input int unsigned gran);
    return (gran == 0) ? 1 : dw / gran;
  endfunction

  // Bit i of the result comes from new_w when the lane holding bit i is enabled.
  function automatic logic [MAX_DATA_W-1:0] merge_lanes(
    input logic [MAX_DATA_W-1:0] old_w,
    input logic [MAX_DATA_W-1:0] new_w,
    input logic [MAX_LANES-1:0]  mask,
    input int unsigned           gran
  );
    logic [MAX_DATA_W-1:0] res;
    res = old_w;
    for (int unsigned i = 0; i < MAX_DATA_W; i++) begin
      if (mask[i / gran]) res[i] = new_w[i];
    end
    return res;
  endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Per-port read return path: one mandatory result flop plus an optional extra
// output stage; outputs are forced to zero while reset is asserted.
module sram_rd_pipe #(
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned OUT_REG    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_valid,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid
);

  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_data;
  logic                  q_valid;
  logic [DATA_WIDTH-1:0] q_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= rd_valid;
      if (rd_valid) s1_data <= rd_data;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic                  s2_valid;
    logic [DATA_WIDTH-1:0] s2_data;

    always_ff @(posedge clk) begin
      if (rst) begin
        s2_valid <= 1'b0;
        s2_data  <= '0;
      end else begin
        s2_valid <= s1_valid;
        if (s1_valid) s2_data <= s1_data;
      end
    end

    assign q_valid = s2_valid;
    assign q_data  = s2_data;
  end else begin : g_no_out_reg
    assign q_valid = s1_valid;
    assign q_data  = s1_data;
  end

  // A result landing while rst is high is an in-flight read and must be dropped.
  assign rvalid = q_valid & ~rst;
  assign rdata  = rst ? '0 : q_data;

endmodule

// File: rtl/sram_dp_fwd.sv
// Parametrised true dual-port RW memory with per-entry valid bits, port-0-wins
// lane resolution on write collisions and write-first cross-port forwarding.
module sram_dp_fwd
  import sram_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 256,
  parameter  int unsigned ADDR_WIDTH = 4,
  parameter  int unsigned MASK_GRAN  = 8,
  parameter  int unsigned OUT_REG    = 0,
  localparam int unsigned NUM_WMASKS = num_wmasks(DATA_WIDTH, MASK_GRAN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en0,
  input  logic                  we0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic                  rvalid0,
  input  logic                  en1,
  input  logic                  we1,
  input  logic [NUM_WMASKS-1:0] wmask1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  rvalid1
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  if ((DATA_WIDTH % MASK_GRAN) != 0) begin : g_bad_gran
    $error("sram_dp_fwd: DATA_WIDTH must be a multiple of MASK_GRAN");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]      valid;
  req_e                  op0, op1;
  logic [DATA_WIDTH-1:0] post0, post1;

  function automatic req_e decode(input logic en, input logic we, input logic any_lane, input logic r);
    if (r || !en) return REQ_IDLE;
    if (!we)      return REQ_READ;
    return any_lane ? REQ_WRITE : REQ_IDLE;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] merge(
    input logic [DATA_WIDTH-1:0] old_w,
    input logic [DATA_WIDTH-1:0] new_w,
    input logic [NUM_WMASKS-1:0] mask
  );
    logic [MAX_DATA_W-1:0] o_x, n_x, r_x;
    logic [MAX_LANES-1:0]  m_x;
    o_x = '0;
    n_x = '0;
    m_x = '0;
    o_x[DATA_WIDTH-1:0] = old_w;
    n_x[DATA_WIDTH-1:0] = new_w;
    m_x[NUM_WMASKS-1:0] = mask;
    r_x = merge_lanes(o_x, n_x, m_x, MASK_GRAN);
    return r_x[DATA_WIDTH-1:0];
  endfunction

  assign op0 = decode(en0, we0, |wmask0, rst);
  assign op1 = decode(en1, we1, |wmask1, rst);

  // Post-write word at each port's address: port 1 lanes first, then port 0 on top,
  // so overlapping lanes resolve to port 0 and reads see the write (write-first).
  always_comb begin
    post0 = valid[addr0] ? mem[addr0] : '0;
    if (op1 == REQ_WRITE && addr1 == addr0) post0 = merge(post0, wdata1, wmask1);
    if (op0 == REQ_WRITE)                   post0 = merge(post0, wdata0, wmask0);

    post1 = valid[addr1] ? mem[addr1] : '0;
    if (op1 == REQ_WRITE)                   post1 = merge(post1, wdata1, wmask1);
    if (op0 == REQ_WRITE && addr0 == addr1) post1 = merge(post1, wdata0, wmask0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else begin
      if (op0 == REQ_WRITE) valid[addr0] <= 1'b1;
      if (op1 == REQ_WRITE) valid[addr1] <= 1'b1;
    end
  end

  // Same-address dual writes store the identical resolved word from both ports.
  always_ff @(posedge clk) begin
    if (op0 == REQ_WRITE) mem[addr0] <= post0;
    if (op1 == REQ_WRITE) mem[addr1] <= post1;
  end

  sram_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .OUT_REG    (OUT_REG)
  ) u_rd_pipe0 (
    .clk      (clk),
    .rst      (rst),
    .rd_valid (op0 == REQ_READ),
    .rd_data  (post0),
    .rdata    (rdata0),
    .rvalid   (rvalid0)
  );

  sram_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .OUT_REG    (OUT_REG)
  ) u_rd_pipe1 (
    .clk      (clk),
    .rst      (rst),
    .rd_valid (op1 == REQ_READ),
    .rd_data  (post1),
    .rdata    (rdata1),
    .rvalid   (rvalid1)
  );

endmodule

// File: tb/tb_sram_dp_fwd.sv
// Bench for sram_dp_fwd: two instances (OUT_REG=0 and OUT_REG=1) share stimulus and
// are checked every cycle against a lane-level reference model of the memory.
module tb_sram_dp_fwd;

  logic         clk = 1'b0;
  logic         rst, en0, we0, en1, we1;
  logic [31:0]  wmask0, wmask1;
  logic [3:0]   addr0, addr1;
  logic [255:0] wdata0, wdata1;
  logic [255:0] ra0, ra1, rb0, rb1;
  logic         rva0, rva1, rvb0, rvb1;

  int tests = 0;
  int fails = 0;

  logic [255:0] m_mem [16];
  logic         m_vld [16];
  logic [255:0] ea_d [2];
  logic         ea_v [2];
  logic [255:0] eb_d [2];
  logic         eb_v [2];
  logic [255:0] pd [2];
  logic         pv [2];

  always #5 clk = ~clk;

  sram_dp_fwd #(.OUT_REG(0)) dut_a (
    .clk(clk), .rst(rst),
    .en0(en0), .we0(we0), .wmask0(wmask0), .addr0(addr0), .wdata0(wdata0),
    .rdata0(ra0), .rvalid0(rva0),
    .en1(en1), .we1(we1), .wmask1(wmask1), .addr1(addr1), .wdata1(wdata1),
    .rdata1(ra1), .rvalid1(rva1)
  );

  sram_dp_fwd #(.OUT_REG(1)) dut_b (
    .clk(clk), .rst(rst),
    .en0(en0), .we0(we0), .wmask0(wmask0), .addr0(addr0), .wdata0(wdata0),
    .rdata0(rb0), .rvalid0(rvb0),
    .en1(en1), .we1(we1), .wmask1(wmask1), .addr1(addr1), .wdata1(wdata1),
    .rdata1(rb1), .rvalid1(rvb1)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk256(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: memory as 16 words of 32 byte lanes; an invalid word reads as zero.
  task automatic model_edge();
    logic [255:0] nxt [16];
    logic         w0, w1;
    logic         res_v [2];
    logic [255:0] res_d [2];
    if (rst) begin
      for (int a = 0; a < 16; a++) m_vld[a] = 1'b0;
      for (int p = 0; p < 2; p++) begin
        ea_v[p] = 1'b0; ea_d[p] = '0;
        eb_v[p] = 1'b0; eb_d[p] = '0;
        pv[p]   = 1'b0; pd[p]   = '0;
      end
      return;
    end
    w0 = en0 && we0 && (wmask0 != 32'd0);
    w1 = en1 && we1 && (wmask1 != 32'd0);
    for (int a = 0; a < 16; a++) begin
      nxt[a] = m_vld[a] ? m_mem[a] : '0;
      for (int l = 0; l < 32; l++) begin
        if (w0 && int'(addr0) == a && wmask0[l])
          nxt[a][l*8 +: 8] = wdata0[l*8 +: 8];
        else if (w1 && int'(addr1) == a && wmask1[l])
          nxt[a][l*8 +: 8] = wdata1[l*8 +: 8];
      end
    end
    res_v[0] = en0 && !we0;
    res_v[1] = en1 && !we1;
    res_d[0] = nxt[addr0];
    res_d[1] = nxt[addr1];
    if (w0) begin m_mem[addr0] = nxt[addr0]; m_vld[addr0] = 1'b1; end
    if (w1) begin m_mem[addr1] = nxt[addr1]; m_vld[addr1] = 1'b1; end
    for (int p = 0; p < 2; p++) begin
      eb_v[p] = pv[p];
      if (pv[p]) eb_d[p] = pd[p];
      pv[p] = res_v[p];
      if (res_v[p]) pd[p] = res_d[p];
      ea_v[p] = res_v[p];
      if (res_v[p]) ea_d[p] = res_d[p];
    end
  endtask

  task automatic check_all();
    chk1  ("a_rvalid0", rva0, ea_v[0]);
    chk256("a_rdata0",  ra0,  ea_d[0]);
    chk1  ("a_rvalid1", rva1, ea_v[1]);
    chk256("a_rdata1",  ra1,  ea_d[1]);
    chk1  ("b_rvalid0", rvb0, eb_v[0]);
    chk256("b_rdata0",  rb0,  eb_d[0]);
    chk1  ("b_rvalid1", rvb1, eb_v[1]);
    chk256("b_rdata1",  rb1,  eb_d[1]);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle();
    en0 = 1'b0; we0 = 1'b0; wmask0 = '0; addr0 = '0; wdata0 = '0;
    en1 = 1'b0; we1 = 1'b0; wmask1 = '0; addr1 = '0; wdata1 = '0;
  endtask

  function automatic logic [255:0] rnd256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [255:0] tmp;
    logic [1:0]   sel;
    rst = 1'b1;
    idle();
    step();
    step();
    chk256("reset_rdata0", ra0, '0);
    chk1  ("reset_rvalid1", rvb1, 1'b0);
    rst = 1'b0;

    // read of never-written entry after reset
    en0 = 1'b1; addr0 = 4'd3;
    step();
    chk1  ("tp1_rvalid0", rva0, 1'b1);
    chk256("tp1_rdata0",  ra0,  '0);
    idle();

    // partial write then read on the other port next cycle
    tmp = rnd256();
    tmp[31:0] = 32'hDEADBEEF;
    en0 = 1'b1; we0 = 1'b1; addr0 = 4'd5; wdata0 = tmp; wmask0 = 32'h0000000F;
    step();
    idle();
    en1 = 1'b1; addr1 = 4'd5;
    step();
    chk256("tp2_rdata1", ra1, 256'hDEADBEEF);
    idle();

    // same-cycle write/write collision, overlap lane goes to port 0
    en0 = 1'b1; we0 = 1'b1; addr0 = 4'd2; wdata0 = 256'hAAAA;   wmask0 = 32'h3;
    en1 = 1'b1; we1 = 1'b1; addr1 = 4'd2; wdata1 = 256'hBBBBBB; wmask1 = 32'h6;
    step();
    idle();
    en0 = 1'b1; addr0 = 4'd2;
    step();
    chk256("tp3_rdata0", ra0, 256'hBBAAAA);
    idle();

    // cross-port read/write same address: write-first
    en0 = 1'b1; addr0 = 4'd7;
    en1 = 1'b1; we1 = 1'b1; addr1 = 4'd7; wdata1 = 256'h1234; wmask1 = '1;
    step();
    chk256("tp4_rdata0", ra0, 256'h1234);
    idle();

    // back-to-back reads through the OUT_REG=1 instance
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin en1 = 1'b1; addr1 = 4'(2 + i); end
      else idle();
      step();
      chk1("tp5_b_rvalid1", rvb1, (i >= 1 && i <= 4));
    end
    idle();

    // reset with reads in flight
    en0 = 1'b1; we0 = 1'b1; addr0 = 4'd9; wdata0 = rnd256(); wmask0 = '1;
    step();
    idle();
    en0 = 1'b1; addr0 = 4'd9;
    step();
    idle();
    rst = 1'b1;
    #1;
    chk1  ("tp6_a_rvalid0_in_rst", rva0, 1'b0);
    chk256("tp6_a_rdata0_in_rst",  ra0,  '0);
    step();
    rst = 1'b0;
    step();
    chk1("tp6_b_rvalid0_dropped", rvb0, 1'b0);
    en0 = 1'b1; addr0 = 4'd9;
    step();
    idle();
    chk256("tp6_a_rdata0_after_rst", ra0, '0);
    step();
    chk1  ("tp6_b_rvalid0_after_rst", rvb0, 1'b1);
    chk256("tp6_b_rdata0_after_rst",  rb0,  '0);

    // randomized traffic, addresses biased low to force collisions
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      en0 = $urandom_range(0, 3) != 0;
      we0 = $urandom_range(0, 1) == 1;
      en1 = $urandom_range(0, 3) != 0;
      we1 = $urandom_range(0, 1) == 1;
      addr0 = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
      addr1 = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
      sel = 2'($urandom);
      wmask0 = (sel == 2'd0) ? 32'd0 : (sel == 2'd1) ? '1 : $urandom;
      sel = 2'($urandom);
      wmask1 = (sel == 2'd0) ? 32'd0 : (sel == 2'd1) ? '1 : $urandom;
      wdata0 = rnd256();
      wdata1 = rnd256();
      step();
    end
    rst = 1'b0;
    idle();
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
